// File: rtl/weight_control_if.sv
// Instruction and weight-path signals of the weight load sequencer.
// slave: the sequencer side; master: the coordinator / buffer / array side.
interface weight_control_if #(
    parameter int WEIGHT_ADDR_WIDTH = 40,
    parameter int LENGTH_WIDTH      = 32,
    parameter int ROW_WIDTH         = 4
);
    logic [WEIGHT_ADDR_WIDTH-1:0] instr_address;
    logic [LENGTH_WIDTH-1:0]      instr_length;
    logic                         instr_enable;
    logic                         busy;
    logic                         resource_busy;
    logic                         weight_buffer_en;
    logic [WEIGHT_ADDR_WIDTH-1:0] weight_buffer_addr;
    logic                         load_weight;
    logic [ROW_WIDTH-1:0]         weight_row;
    logic                         weight_zero;

    modport slave (
        input  instr_address, instr_length, instr_enable,
        output busy, resource_busy, weight_buffer_en, weight_buffer_addr,
               load_weight, weight_row, weight_zero
    );

    modport master (
        output instr_address, instr_length, instr_enable,
        input  busy, resource_busy, weight_buffer_en, weight_buffer_addr,
               load_weight, weight_row, weight_zero
    );
endinterface

// File: rtl/weight_control.sv
// Weight load sequencer: one buffer read per row, load strobe READ_LATENCY cycles later.
// Optional macro WEIGHT_CONTROL_ZERO_PAD_EN pads partial tiles with zero rows.
module weight_control #(
    parameter int MATRIX_WIDTH      = 14,
    parameter int WEIGHT_ADDR_WIDTH = 40,
    parameter int LENGTH_WIDTH      = 32,
    parameter int READ_LATENCY      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    weight_control_if.slave  bus
);
    localparam int AW    = WEIGHT_ADDR_WIDTH;
    localparam int LW    = LENGTH_WIDTH;
    localparam int ROW_W = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MATRIX_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_r, next_state_s;
    logic [AW-1:0]     base_r, base_s, addr_r, addr_s;
    logic [LW-1:0]     len_r, len_s, issued_r, issued_s;
    logic [ROW_W-1:0]  row_cnt_r, row_cnt_s, row_inc_s, issue_row_r, issue_row_s;
    logic              issue_vld_r, issue_vld_s, en_r, en_s;
    logic              accept_s, more_s, done_s, pending_s, dl_any_s;
    logic              dl_vld_r [READ_LATENCY];
    logic [ROW_W-1:0]  dl_row_r [READ_LATENCY];
`ifdef WEIGHT_CONTROL_ZERO_PAD_EN
    logic              issue_zero_r, issue_zero_s;
    logic              dl_zero_r [READ_LATENCY];
`endif

    // The row counter persists across instructions and wraps at the tile edge.
    assign row_inc_s = (row_cnt_r == LAST_ROW) ? {ROW_W{1'b0}} : row_cnt_r + ROW_W'(1);
    assign accept_s  = bus.instr_enable && (bus.instr_length != {LW{1'b0}}) && (state_r != ISSUE);
    assign more_s    = (issued_r < len_r);
`ifdef WEIGHT_CONTROL_ZERO_PAD_EN
    assign done_s    = !more_s && (row_cnt_r == {ROW_W{1'b0}});
`else
    assign done_s    = !more_s;
`endif

    // Delay-line occupancy; pending ignores the last stage, which empties on this edge.
    always_comb begin
        pending_s = issue_vld_r;
        dl_any_s  = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            dl_any_s  = dl_any_s | dl_vld_r[i];
            pending_s = pending_s | (dl_vld_r[i] & (i < READ_LATENCY - 1));
        end
    end

    // Next state and the issue slot registered at the coming edge.
    always_comb begin
        next_state_s = state_r;
        base_s       = base_r;
        len_s        = len_r;
        issued_s     = issued_r;
        row_cnt_s    = row_cnt_r;
        issue_vld_s  = 1'b0;
        issue_row_s  = issue_row_r;
        en_s         = 1'b0;
        addr_s       = addr_r;
`ifdef WEIGHT_CONTROL_ZERO_PAD_EN
        issue_zero_s = 1'b0;
`endif
        case (state_r)
            IDLE, DRAIN: begin
                if (accept_s) begin
                    next_state_s = ISSUE;
                    base_s       = bus.instr_address;
                    len_s        = bus.instr_length;
                    issued_s     = LW'(1);
                    issue_vld_s  = 1'b1;
                    issue_row_s  = row_cnt_r;
                    row_cnt_s    = row_inc_s;
                    en_s         = 1'b1;
                    addr_s       = bus.instr_address;
                end else if ((state_r == DRAIN) && !pending_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            ISSUE: begin
                if (done_s) begin
                    next_state_s = DRAIN;
                end else begin
                    issue_vld_s = 1'b1;
                    issue_row_s = row_cnt_r;
                    row_cnt_s   = row_inc_s;
                    issued_s    = issued_r + LW'(1);
                    if (more_s) begin
                        en_s   = 1'b1;
                        addr_s = base_r + AW'(issued_r);
                    end else begin
                        en_s = 1'b0;
`ifdef WEIGHT_CONTROL_ZERO_PAD_EN
                        issue_zero_s = 1'b1;
`endif
                    end
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, issue registers and the {valid, row} delay line; all hold while enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            base_r      <= {AW{1'b0}};
            len_r       <= {LW{1'b0}};
            issued_r    <= {LW{1'b0}};
            row_cnt_r   <= {ROW_W{1'b0}};
            issue_vld_r <= 1'b0;
            issue_row_r <= {ROW_W{1'b0}};
            en_r        <= 1'b0;
            addr_r      <= {AW{1'b0}};
`ifdef WEIGHT_CONTROL_ZERO_PAD_EN
            issue_zero_r <= 1'b0;
`endif
            for (int i = 0; i < READ_LATENCY; i++) begin
                dl_vld_r[i] <= 1'b0;
                dl_row_r[i] <= {ROW_W{1'b0}};
`ifdef WEIGHT_CONTROL_ZERO_PAD_EN
                dl_zero_r[i] <= 1'b0;
`endif
            end
        end else if (enable) begin
            state_r     <= next_state_s;
            base_r      <= base_s;
            len_r       <= len_s;
            issued_r    <= issued_s;
            row_cnt_r   <= row_cnt_s;
            issue_vld_r <= issue_vld_s;
            issue_row_r <= issue_row_s;
            en_r        <= en_s;
            addr_r      <= addr_s;
            dl_vld_r[0] <= issue_vld_r;
            dl_row_r[0] <= issue_row_r;
`ifdef WEIGHT_CONTROL_ZERO_PAD_EN
            issue_zero_r <= issue_zero_s;
            dl_zero_r[0] <= issue_zero_r;
`endif
            for (int i = 1; i < READ_LATENCY; i++) begin
                dl_vld_r[i] <= dl_vld_r[i-1];
                dl_row_r[i] <= dl_row_r[i-1];
`ifdef WEIGHT_CONTROL_ZERO_PAD_EN
                dl_zero_r[i] <= dl_zero_r[i-1];
`endif
            end
        end
    end

    assign bus.busy               = (state_r == ISSUE);
    assign bus.resource_busy      = (state_r != IDLE) || dl_any_s;
    assign bus.weight_buffer_en   = en_r;
    assign bus.weight_buffer_addr = addr_r;
    assign bus.load_weight        = dl_vld_r[READ_LATENCY-1];
    assign bus.weight_row         = dl_row_r[READ_LATENCY-1];
`ifdef WEIGHT_CONTROL_ZERO_PAD_EN
    assign bus.weight_zero        = dl_zero_r[READ_LATENCY-1];
`else
    assign bus.weight_zero        = 1'b0;
`endif
endmodule

// File: tb/tb_weight_control.sv
// Bench for weight_control: directed scenarios plus random traffic checked against
// a closed-form schedule of accepted instructions indexed by enabled-cycle count.
module tb_weight_control;
    localparam int MW    = 14;
    localparam int AW    = 40;
    localparam int LW    = 32;
    localparam int R     = 2;
    localparam int ROW_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;

    weight_control_if #(.WEIGHT_ADDR_WIDTH(AW), .LENGTH_WIDTH(LW), .ROW_WIDTH(ROW_W)) bus_if ();

    weight_control #(
        .MATRIX_WIDTH(MW), .WEIGHT_ADDR_WIDTH(AW), .LENGTH_WIDTH(LW), .READ_LATENCY(R)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint         e0;
        logic [AW-1:0]  base;
        int             n;
        int             ntot;
        int             r0;
    } inst_t;

    inst_t  q[$];
    longint e_cnt  = 0;
    int     row_ptr = 0;
    int     checks = 0;
    int     errors = 0;

    logic             x_en, x_load, x_zero, x_busy, x_rb;
    logic [AW-1:0]    x_addr;
    logic [ROW_W-1:0] x_row;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs at enabled-cycle index e_cnt from every accepted instruction.
    task automatic model_eval();
        longint k, kk;
        x_en = 1'b0; x_load = 1'b0; x_zero = 1'b0; x_busy = 1'b0; x_rb = 1'b0;
        x_addr = '0; x_row = '0;
        foreach (q[i]) begin
            k  = e_cnt - q[i].e0;
            kk = k - R;
            if (k >= 0 && k < q[i].ntot) x_busy = 1'b1;
            if (k >= 0 && k < q[i].n) begin
                x_en   = 1'b1;
                x_addr = q[i].base + AW'(k);
            end
            if (kk >= 0 && kk < q[i].ntot) begin
                x_load = 1'b1;
                x_row  = ROW_W'((longint'(q[i].r0) + kk) % MW);
                x_zero = (kk >= q[i].n);
            end
            if (k >= 0 && k < q[i].ntot + R) x_rb = 1'b1;
        end
    endtask

    task automatic model_step();
        int n, ntot, rem;
        if (enable) begin
            e_cnt++;
            if (bus_if.instr_enable && bus_if.instr_length != '0) begin
                n    = int'(bus_if.instr_length);
                ntot = n;
`ifdef WEIGHT_CONTROL_ZERO_PAD_EN
                rem = (row_ptr + n) % MW;
                if (rem != 0) ntot = n + MW - rem;
`else
                rem = 0;
`endif
                q.push_back('{e_cnt, bus_if.instr_address, n, ntot, row_ptr});
                row_ptr = (row_ptr + ntot) % MW;
            end
            while (q.size() > 0 && e_cnt > q[0].e0 + q[0].ntot + R) void'(q.pop_front());
        end
    endtask

    task automatic check_outputs();
        model_eval();
        check_eq("weight_buffer_en", bus_if.weight_buffer_en, x_en);
        if (x_en) check_eq("weight_buffer_addr", bus_if.weight_buffer_addr, x_addr);
        check_eq("load_weight", bus_if.load_weight, x_load);
        if (x_load) check_eq("weight_row", bus_if.weight_row, x_row);
        check_eq("weight_zero", bus_if.weight_zero, x_zero);
        check_eq("busy", bus_if.busy, x_busy);
        check_eq("resource_busy", bus_if.resource_busy, x_rb);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_en"},    bus_if.weight_buffer_en, 64'd0);
        check_eq({tag, "_addr"},  bus_if.weight_buffer_addr, 64'd0);
        check_eq({tag, "_load"},  bus_if.load_weight, 64'd0);
        check_eq({tag, "_row"},   bus_if.weight_row, 64'd0);
        check_eq({tag, "_zero"},  bus_if.weight_zero, 64'd0);
        check_eq({tag, "_busy"},  bus_if.busy, 64'd0);
        check_eq({tag, "_rbusy"}, bus_if.resource_busy, 64'd0);
    endtask

    // One clock: check at negedge, drive, then advance the model past the posedge.
    task automatic cycle(input logic en, input logic ie, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        @(negedge clk);
        check_outputs();
        enable                = en;
        bus_if.instr_enable   = ie && en && !x_busy;
        bus_if.instr_address  = addr;
        bus_if.instr_length   = len;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b0, '0, '0);
            if (!x_rb) break;
        end
        idle(2);
    endtask

    initial begin
        logic [63:0] r64;
        logic        en_r;
        logic        ie_r;
        logic [AW-1:0] a_r;
        bus_if.instr_enable  = 1'b0;
        bus_if.instr_address = '0;
        bus_if.instr_length  = '0;

        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        cycle(1'b1, 1'b1, 40'h100, 32'd14);             // basic tile
        drain();
        cycle(1'b1, 1'b1, 40'h2000, 32'd30);            // multi-tile
        drain();
        cycle(1'b1, 1'b1, 40'h300, 32'd14);             // stall mid-ISSUE
        idle(4);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, '0);
        drain();
        cycle(1'b1, 1'b1, 40'h555, 32'd0);              // no-op
        idle(4);
        cycle(1'b1, 1'b1, 40'hFF_FFFF_FFFE, 32'd4);     // address wrap
        drain();
        cycle(1'b1, 1'b1, 40'h10, 32'd3);               // accept during DRAIN
        idle(3);
        cycle(1'b1, 1'b1, 40'h40, 32'd5);
        drain();

        cycle(1'b1, 1'b1, 40'h700, 32'd14);             // async reset mid-ISSUE
        idle(5);
        #3;
        rst = 1'b1;
        q.delete();
        row_ptr = 0;
        #1;
        check_all_zero("async_rst");
        bus_if.instr_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b1, 40'h900, 32'd3);
        drain();

        for (int i = 0; i < 400; i++) begin
            r64  = {$urandom, $urandom};
            en_r = ($urandom_range(0, 7) != 0);
            ie_r = ($urandom_range(0, 5) == 0);
            a_r  = ($urandom_range(0, 3) == 0) ? ({AW{1'b1}} - AW'($urandom_range(0, 20))) : r64[AW-1:0];
            cycle(en_r, ie_r, a_r, LW'($urandom_range(0, 32)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
